ea_sequencer: RTL and testbench

- Multi-cycle effective-address (EA) sequencer for the 6502 core.
- Owns the shared 16-bit ALU while an operand address is resolved. It drives alu_op/op_A/op_B, registers the ALU result, and issues zero-page pointer reads for indirect modes.
- Sits between decode (start, mode, operand, X/Y) and the memory/execute stage, which consumes ea_o through a valid/ready handshake.

---
 rtl/ea_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_ea_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ea_sequencer.sv
// ea_sequencer: multi-cycle 6502 effective-address resolver; valid at +2 (direct/indexed), +4 IND_X, +5 IND_Y, +1 per memory wait.
// EA held in DONE until ea_ready_i; start ignored while busy. Macro EA_PAGE_CROSS_PENALTY_EN adds a PENALTY cycle on page cross.
package ea_pkg;
  typedef enum logic [1:0] {
    ALU_BYPASS_A     = 2'd0,
    ALU_ADD          = 2'd1,
    ALU_ADD_ZEROPAGE = 2'd2
  } alu_op_t;

  localparam logic [2:0] MODE_ZP    = 3'd0;
  localparam logic [2:0] MODE_ZP_X  = 3'd1;
  localparam logic [2:0] MODE_ZP_Y  = 3'd2;
  localparam logic [2:0] MODE_ABS   = 3'd3;
  localparam logic [2:0] MODE_ABS_X = 3'd4;
  localparam logic [2:0] MODE_ABS_Y = 3'd5;
  localparam logic [2:0] MODE_IND_X = 3'd6;
  localparam logic [2:0] MODE_IND_Y = 3'd7;
endpackage

module ea_sequencer
  import ea_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [2:0]        mode_i,
  input  logic [ADDR_W-1:0] operand_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  output alu_op_t           alu_op_o,
  output logic [ADDR_W-1:0] alu_a_o,
  output logic [ADDR_W-1:0] alu_b_o,
  input  logic [ADDR_W-1:0] alu_res_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              ea_valid_o,
  input  logic              ea_ready_i,
  output logic [ADDR_W-1:0] ea_o,
  output logic              page_cross_o,
  output logic              busy_o
);
  localparam int HW = ADDR_W - DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_PTR_LO,
    S_PTR_HI,
    S_IDX,
`ifdef EA_PAGE_CROSS_PENALTY_EN
    S_PENALTY,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        mode_q;
  logic [ADDR_W-1:0] op_q, ptr_q, ea_q;
  logic [DATA_W-1:0] x_q, y_q, lo_q, hi_q;
  logic              pc_q, pc_calc;

  function automatic logic [ADDR_W-1:0] zx(input logic [DATA_W-1:0] v);
    return {{HW{1'b0}}, v};
  endfunction

  always_comb begin
    state_d    = state_q;
    alu_op_o   = ALU_BYPASS_A;
    alu_a_o    = '0;
    alu_b_o    = '0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    ea_valid_o = 1'b0;
    busy_o     = (state_q != S_IDLE);
    pc_calc    = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_CALC;
      S_CALC: begin
        case (mode_q)
          MODE_ZP: begin
            alu_a_o = zx(op_q[DATA_W-1:0]);
            state_d = S_DONE;
          end
          MODE_ZP_X, MODE_ZP_Y: begin
            alu_op_o = ALU_ADD_ZEROPAGE;
            alu_a_o  = op_q;
            alu_b_o  = zx((mode_q == MODE_ZP_X) ? x_q : y_q);
            state_d  = S_DONE;
          end
          MODE_ABS: begin
            alu_a_o = op_q;
            state_d = S_DONE;
          end
          MODE_ABS_X, MODE_ABS_Y: begin
            alu_op_o = ALU_ADD;
            alu_a_o  = op_q;
            alu_b_o  = zx((mode_q == MODE_ABS_X) ? x_q : y_q);
            pc_calc  = (alu_res_i[ADDR_W-1:DATA_W] != op_q[ADDR_W-1:DATA_W]);
            state_d  = S_DONE;
          end
          MODE_IND_X: begin
            alu_op_o = ALU_ADD_ZEROPAGE;
            alu_a_o  = op_q;
            alu_b_o  = zx(x_q);
            state_d  = S_PTR_LO;
          end
          default: begin
            alu_a_o = zx(op_q[DATA_W-1:0]);
            state_d = S_PTR_LO;
          end
        endcase
      end
      S_PTR_LO: begin
        mem_req_o  = 1'b1;
        mem_addr_o = ptr_q;
        // Next pointer byte stays inside page 0 (0x00FF -> 0x0000).
        alu_op_o   = ALU_ADD_ZEROPAGE;
        alu_a_o    = ptr_q;
        alu_b_o    = ADDR_W'(1);
        if (mem_ack_i) state_d = S_PTR_HI;
      end
      S_PTR_HI: begin
        mem_req_o  = 1'b1;
        mem_addr_o = ptr_q;
        if (mem_ack_i) state_d = (mode_q == MODE_IND_X) ? S_DONE : S_IDX;
      end
      S_IDX: begin
        alu_op_o = ALU_ADD;
        alu_a_o  = ADDR_W'({hi_q, lo_q});
        alu_b_o  = zx(y_q);
        pc_calc  = (alu_res_i[ADDR_W-1:DATA_W] != hi_q);
        state_d  = S_DONE;
      end
`ifdef EA_PAGE_CROSS_PENALTY_EN
      S_PENALTY: state_d = S_DONE;
`endif
      S_DONE: begin
        ea_valid_o = 1'b1;
        if (ea_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef EA_PAGE_CROSS_PENALTY_EN
    if (((state_q == S_CALC) || (state_q == S_IDX)) && pc_calc) state_d = S_PENALTY;
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ptr_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      ea_q    <= '0;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start_i) begin
          mode_q <= mode_i;
          op_q   <= operand_i;
          x_q    <= x_i;
          y_q    <= y_i;
        end
        S_CALC: begin
          if ((mode_q == MODE_IND_X) || (mode_q == MODE_IND_Y)) ptr_q <= alu_res_i;
          else ea_q <= alu_res_i;
          pc_q <= pc_calc;
        end
        S_PTR_LO: if (mem_ack_i) begin
          lo_q  <= mem_rdata_i;
          ptr_q <= alu_res_i;
        end
        S_PTR_HI: if (mem_ack_i) begin
          hi_q <= mem_rdata_i;
          if (mode_q == MODE_IND_X) ea_q <= ADDR_W'({mem_rdata_i, lo_q});
        end
        S_IDX: begin
          ea_q <= alu_res_i;
          pc_q <= pc_calc;
        end
        default: ;
      endcase
    end
  end

  assign ea_o         = ea_q;
  assign page_cross_o = pc_q;
endmodule

// File: tb/tb_ea_sequencer.sv
// Directed bench for ea_sequencer: behavioural ALU and zero-page memory, scoreboard of expected EAs.
module tb_ea_sequencer;
  import ea_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  mode_i = '0;
  logic [15:0] operand_i = '0;
  logic [7:0]  x_i = '0, y_i = '0;
  alu_op_t     alu_op_o;
  logic [15:0] alu_a_o, alu_b_o, alu_res_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;
  logic        ea_valid_o;
  logic        ea_ready_i = 1'b1;
  logic [15:0] ea_o;
  logic        page_cross_o, busy_o;

  ea_sequencer #(.DATA_W(8), .ADDR_W(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .mode_i(mode_i),
    .operand_i(operand_i), .x_i(x_i), .y_i(y_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_res_i(alu_res_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .ea_valid_o(ea_valid_o), .ea_ready_i(ea_ready_i),
    .ea_o(ea_o), .page_cross_o(page_cross_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    case (alu_op_o)
      ALU_ADD:          alu_res_i = alu_a_o + alu_b_o;
      ALU_ADD_ZEROPAGE: alu_res_i = {8'h00, alu_a_o[7:0] + alu_b_o[7:0]};
      default:          alu_res_i = alu_a_o;
    endcase
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  logic [16:0] exp_q[$];
  logic [15:0] addr_q[$];

  always @(negedge clk_i) begin
    if (rstn_i && ea_valid_o && ea_ready_i) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("sb_ea", ea_o, e[15:0]);
        chk("sb_page_cross", page_cross_o, e[16]);
      end
    end
  end

  logic [7:0]  mem [256];
  int          ack_delay = 0;
  int          wcnt = 0;
  logic [15:0] held = '0;

  always @(negedge clk_i) begin
    if (mem_req_o) begin
      if (wcnt > 0) chk("mem_addr_stable", mem_addr_o, held);
      held = mem_addr_o;
      if (wcnt == ack_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem[mem_addr_o[7:0]];
        addr_q.push_back(mem_addr_o);
        wcnt = 0;
      end else begin
        mem_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack_i = 1'b0;
      wcnt = 0;
    end
  end

  task automatic start_txn(input logic [2:0] mode, input logic [15:0] op, input logic [7:0] x,
                           input logic [7:0] y, input logic [15:0] exp_ea, input logic exp_pc);
    @(posedge clk_i); #1;
    mode_i = mode; operand_i = op; x_i = x; y_i = y; start_i = 1'b1;
    exp_q.push_back({exp_pc, exp_ea});
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output alu_op_t calc_op);
    cyc = 1;
    @(negedge clk_i);
    calc_op = alu_op_o;
    while (!ea_valid_o && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] mode, input logic [15:0] op,
                     input logic [7:0] x, input logic [7:0] y, input int delay,
                     input logic [15:0] exp_ea, input logic exp_pc, input int exp_lat,
                     input alu_op_t exp_calc_op);
    int cyc;
    alu_op_t cop;
    ack_delay = delay;
    addr_q.delete();
`ifdef EA_PAGE_CROSS_PENALTY_EN
    if (exp_pc) exp_lat++;
`endif
    start_txn(mode, op, x, y, exp_ea, exp_pc);
    wait_valid(cyc, cop);
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_calc_alu_op"}, cop, exp_calc_op);
    @(posedge clk_i); #1;
    chk({tag, "_idle_after"}, {busy_o, ea_valid_o, mem_req_o}, 0);
    chk({tag, "_idle_alu"}, {alu_op_o, alu_a_o, alu_b_o}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    alu_op_t cop;
    logic found;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12;
    mem[8'h40] = 8'hF0; mem[8'h41] = 8'h20;
    mem[8'h50] = 8'h00; mem[8'h51] = 8'h30;
    mem[8'h60] = 8'h11; mem[8'h61] = 8'h22;

    #12;
    chk("rst_flags", {busy_o, ea_valid_o, mem_req_o, page_cross_o}, 0);
    chk("rst_ea", ea_o, 0);
    chk("rst_alu", {alu_op_o, alu_a_o, alu_b_o}, 0);
    @(negedge clk_i); rstn_i = 1'b1;

    run("zp",    MODE_ZP,    16'h3385, 8'h00, 8'h00, 0, 16'h0085, 1'b0, 2, ALU_BYPASS_A);
    run("zp_x",  MODE_ZP_X,  16'h00F0, 8'h20, 8'h00, 0, 16'h0010, 1'b0, 2, ALU_ADD_ZEROPAGE);
    run("zp_y",  MODE_ZP_Y,  16'h00FF, 8'h55, 8'h01, 0, 16'h0000, 1'b0, 2, ALU_ADD_ZEROPAGE);
    run("abs",   MODE_ABS,   16'h1234, 8'h00, 8'h00, 0, 16'h1234, 1'b0, 2, ALU_BYPASS_A);
    run("abs_x", MODE_ABS_X, 16'h12F0, 8'h20, 8'h77, 0, 16'h1310, 1'b1, 2, ALU_ADD);
    run("abs_y", MODE_ABS_Y, 16'h1200, 8'hAA, 8'h10, 0, 16'h1210, 1'b0, 2, ALU_ADD);

    run("ind_x", MODE_IND_X, 16'h00FE, 8'h01, 8'h00, 0, 16'h1234, 1'b0, 4, ALU_ADD_ZEROPAGE);
    chk("ind_x_reads", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      chk("ind_x_addr0", addr_q[0], 16'h00FF);
      chk("ind_x_addr1", addr_q[1], 16'h0000);
    end

    run("ind_y", MODE_IND_Y, 16'h0040, 8'h00, 8'h10, 2, 16'h2100, 1'b1, 9, ALU_BYPASS_A);
    chk("ind_y_reads", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      chk("ind_y_addr0", addr_q[0], 16'h0040);
      chk("ind_y_addr1", addr_q[1], 16'h0041);
    end
    run("ind_y_nc", MODE_IND_Y, 16'h0050, 8'h00, 8'h05, 0, 16'h3005, 1'b0, 5, ALU_BYPASS_A);

    // Consumer stalls for three cycles while start is pulsed.
    ea_ready_i = 1'b0;
    ack_delay = 0;
    start_txn(MODE_ABS, 16'h4567, 8'h00, 8'h00, 16'h4567, 1'b0);
    wait_valid(cyc, cop);
    chk("hold_latency", cyc, 2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      start_i = 1'b1; mode_i = MODE_ZP; operand_i = 16'h0011;
      @(negedge clk_i);
      chk("hold_valid_busy", {ea_valid_o, busy_o}, 2'b11);
      chk("hold_ea", ea_o, 16'h4567);
    end
    @(posedge clk_i); #1;
    start_i = 1'b0; ea_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("hold_release_idle", {busy_o, ea_valid_o}, 0);
    chk("hold_ea_retained", ea_o, 16'h4567);
    chk("hold_sb_drained", exp_q.size(), 0);
    @(posedge clk_i); #1;
    chk("hold_start_ignored", busy_o, 0);

    // Asynchronous reset while the high pointer byte is outstanding.
    ack_delay = 2;
    start_txn(MODE_IND_Y, 16'h0060, 8'h00, 8'h00, 16'h2211, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_i);
      if (mem_req_o && mem_addr_o == 16'h0061) found = 1'b1;
    end
    chk("rst_reached_ptr_hi", found, 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("rst_mid_flags", {mem_req_o, busy_o, ea_valid_o}, 0);
    exp_q.delete();
    @(negedge clk_i);
    #2 rstn_i = 1'b1;

    run("post_rst_zp_x", MODE_ZP_X, 16'h00F0, 8'h20, 8'h00, 0, 16'h0010, 1'b0, 2, ALU_ADD_ZEROPAGE);
    run("post_rst_ind_y", MODE_IND_Y, 16'h0060, 8'h00, 8'h01, 1, 16'h2212, 1'b0, 7, ALU_BYPASS_A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
